// File: rtl/accum4_ctrl.sv
// accum4_ctrl: bit-serial JK-bank accumulator sequencer (optional subtract via ACCUM4_SUB_EN)
module accum4_ctrl #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] din_i,
    input  logic         din_valid_i,
    output logic         din_ready_o,
    input  logic         clr_i,
`ifdef ACCUM4_SUB_EN
    input  logic         sub_i,
`endif
    input  logic [W-1:0] q_i,
    output logic [W-1:0] j_o,
    output logic [W-1:0] k_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         ovf_o
);
    typedef enum logic [1:0] {IDLE, ADD, CLR, DONE} state_e;

    state_e       state_q;
    logic [W-1:0] op_q;
    logic         c_q;
    logic [1:0]   i_q;
    logic         ovf_q;
    logic         busy_q;
    logic         done_q;
    logic         sub_q;
    logic         sub_w;
    logic         qi;
    logic         oi;
    logic         toggle;
    logic         cout;

`ifdef ACCUM4_SUB_EN
    assign sub_w = sub_i;
`else
    assign sub_w = 1'b0;
`endif

    assign qi     = q_i[i_q];
    assign oi     = op_q[i_q];
    assign toggle = oi ^ c_q;
    assign cout   = (qi & oi) | (qi & c_q) | (oi & c_q);

    assign din_ready_o = (state_q == IDLE) && !clr_i;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign ovf_o       = ovf_q;

    // J/K commands decoded from registered state: toggle bit i when the sum bit differs, force-zero all in CLR
    always_comb begin
        j_o = '0;
        k_o = '0;
        if (state_q == ADD && toggle) begin
            j_o[i_q] = 1'b1;
            k_o[i_q] = 1'b1;
        end
        if (state_q == CLR) k_o = '1;
    end

    // Sequencer: accept operand or clear, walk four bits LSB first, pulse done for one cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= '0;
            c_q     <= 1'b0;
            i_q     <= 2'd0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_i) begin
                        state_q <= CLR;
                        busy_q  <= 1'b1;
                    end else if (din_valid_i) begin
                        op_q    <= sub_w ? ~din_i : din_i;
                        c_q     <= sub_w;
                        sub_q   <= sub_w;
                        i_q     <= 2'd0;
                        ovf_q   <= 1'b0;
                        state_q <= ADD;
                        busy_q  <= 1'b1;
                    end
                end
                ADD: begin
                    c_q <= cout;
                    if (i_q == 2'd3) begin
                        ovf_q   <= cout ^ sub_q;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        i_q <= i_q + 2'd1;
                    end
                end
                CLR: begin
                    ovf_q   <= 1'b0;
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_accum4_ctrl.sv
// tb_accum4_ctrl: scoreboard bench for accum4_ctrl driving a behavioural JK bank
module tb_accum4_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din = 4'h0;
    logic       din_valid = 1'b0;
    logic       din_ready_o;
    logic       clr = 1'b0;
    logic       sub = 1'b0;
    logic [3:0] q;
    logic [3:0] j_o;
    logic [3:0] k_o;
    logic       busy_o;
    logic       done_o;
    logic       ovf_o;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    typedef struct {
        logic [3:0] q;
        logic       ovf;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural bank of four JK flip-flops sharing the controller's reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= 4'h0;
        else for (int b = 0; b < 4; b++)
            q[b] <= (j_o[b] & ~q[b]) | (~k_o[b] & q[b]);
    end

    accum4_ctrl dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .din_i(din),
        .din_valid_i(din_valid),
        .din_ready_o(din_ready_o),
        .clr_i(clr),
`ifdef ACCUM4_SUB_EN
        .sub_i(sub),
`endif
        .q_i(q),
        .j_o(j_o),
        .k_o(k_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .ovf_o(ovf_o)
    );

    function automatic void chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic wait_idle();
        bit ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (!busy_o) ok = 1;
        end
        if (!ok) chk("idle_timeout", 1, 0);
    endtask

    task automatic send(input logic [3:0] d, input logic s, input logic [3:0] eq, input logic eo);
        bit ok = 0;
        @(negedge clk);
        din = d;
        sub = s;
        din_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (t > 0) @(negedge clk);
            #1;
            if (din_ready_o) begin
                sb.push_back('{eq, eo, cyc + 5});
                @(posedge clk);
                #1;
                din_valid = 1'b0;
                sub = 1'b0;
                ok = 1;
            end
        end
        if (!ok) chk("handshake_timeout", 1, 0);
    endtask

    task automatic clear();
        wait_idle();
        clr = 1'b1;
        #1;
        sb.push_back('{4'h0, 1'b0, cyc + 2});
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        exp_t e;
        fork
            forever begin
                @(negedge clk);
                if (done_o) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("result_q", int'(q), int'(e.q));
                        chk("result_ovf", int'(ovf_o), int'(e.ovf));
                        chk("done_cycle", cyc, e.cyc);
                    end
                end
            end
        join_none

        din = 4'hA;
        din_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_j", int'(j_o), 0);
        chk("rst_k", int'(k_o), 0);
        chk("rst_ready", int'(din_ready_o), 1);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_ovf", int'(ovf_o), 0);
        chk("rst_q", int'(q), 0);
        din_valid = 1'b0;
        rst_n = 1'b1;

        send(4'h5, 1'b0, 4'h5, 1'b0);
        send(4'h3, 1'b0, 4'h8, 1'b0);
        send(4'h1, 1'b0, 4'h9, 1'b0);
        send(4'h9, 1'b0, 4'h2, 1'b1);
        clear();

        wait_idle();
        clr = 1'b1;
        din = 4'h7;
        din_valid = 1'b1;
        #1;
        chk("clr_prio_ready", int'(din_ready_o), 0);
        sb.push_back('{4'h0, 1'b0, cyc + 2});
        @(posedge clk);
        #1;
        clr = 1'b0;
        send(4'h7, 1'b0, 4'h7, 1'b0);

        wait_idle();
        din = 4'h6;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", int'(busy_o), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy_o), 0);
        chk("mid_rst_jk", int'({j_o, k_o}), 0);
        chk("mid_rst_q", int'(q), 0);
        chk("mid_rst_ready", int'(din_ready_o), 1);
        @(negedge clk);
        rst_n = 1'b1;
        send(4'h4, 1'b0, 4'h4, 1'b0);
        send(4'hB, 1'b0, 4'hF, 1'b0);
        send(4'h1, 1'b0, 4'h0, 1'b1);

`ifdef ACCUM4_SUB_EN
        clear();
        send(4'h3, 1'b0, 4'h3, 1'b0);
        send(4'h5, 1'b1, 4'hE, 1'b1);
        send(4'h4, 1'b1, 4'hA, 1'b0);
`endif

        for (int t = 0; t < 30 && sb.size() > 0; t++) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
